pc_redirect_ctrl: RTL
=====================

# pc_redirect_ctrl

Controls the PC-source 32-bit 2:1 mux and the pipeline-register write/flush controls in the 5-stage pipeline, where branches and jumps resolve in MEM. It registers the redirect target and runs a two-cycle redirect sequence that squashes wrong-path instructions. It also detects load-use hazards and inserts a one-cycle bubble. Two saturating counters record cycles lost to flushes and stalls.

## Interface
- No parameters; all widths fixed (32-bit PC, 5-bit register specifiers).
- Clk  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- BranchTaken_M  in  1  branch/jump in MEM resolved taken this cycle
- Target_M  in  32  redirect target from MEM
- MemRead_E  in  1  instruction in EX is a load
- Rt_E  in  5  load destination register in EX
- Rs_D, Rt_D  in  5 each  source specifiers of instruction in ID
- UsesRt_D  in  1  instruction in ID reads Rt
- PCSrc  out  1  PC mux select: 0 = PC+4 (inA), 1 = RedirectPC (inB)
- RedirectPC  out  32  registered redirect target, drives mux inB
- PCWrite  out  1  PC register load enable
- IFID_Write  out  1  IF/ID register load enable
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  clear the corresponding pipeline register to a bubble on the next edge
- FlushCount  out  32  cycles spent in redirect flush, saturating
- StallCount  out  32  load-use stall cycles, saturating

## Operation
- FSM states: RUN, REDIRECT.
- RUN, BranchTaken_M=1 (cycle t):
  - Capture RedirectPC <= Target_M.
  - Assert IFID_Flush, IDEX_Flush, EXMEM_Flush.
  - PCWrite=0, PCSrc=0, IFID_Write=1.
  - Next state REDIRECT.
  - Takes priority over load-use detection.
- REDIRECT (cycle t+1):
  - PCSrc=1, PCWrite=1, IFID_Flush=1, IDEX_Flush=0, EXMEM_Flush=0, IFID_Write=1.
  - Next state RUN unconditionally.
  - BranchTaken_M and load-use inputs ignored; EX/MEM holds a bubble from cycle t.
- RUN, no branch, load-use hazard:
  - Hazard condition: MemRead_E=1 and Rt_E≠0 and (Rt_E==Rs_D or (UsesRt_D=1 and Rt_E==Rt_D)).
  - PCWrite=0, IFID_Write=0, IDEX_Flush=1, others 0.
  - Stays in RUN.
- RUN idle: PCSrc=0, PCWrite=1, IFID_Write=1, all flushes 0.
- Control outputs are combinational from state and inputs. RedirectPC, the FSM state and the counters are registered.
- FlushCount +1 in every cycle where state is REDIRECT, and in every RUN cycle with BranchTaken_M=1, i.e. +2 per redirect.
- StallCount +1 per load-use stall cycle.
- Both counters hold at 0xFFFFFFFF; no wrap.
- RedirectPC holds its value outside the capture cycle.

## Timing
- Reset (async assert, any state):
  - State RUN, RedirectPC=0x00000000, FlushCount=0, StallCount=0.
  - Combinational outputs immediately take RUN-idle values: PCSrc=0, PCWrite=1, IFID_Write=1, flushes 0.
- Reset deassertion takes effect at the next rising edge. Reset mid-REDIRECT abandons the redirect; no PC load from RedirectPC occurs.
- Redirect latency: taken in MEM at cycle t → PC loads target at the end of t+1 → target instruction in IF at t+2.
  - Penalty: 4 cycles total (3 squashed in-flight plus 1 held fetch).
- Load-use stall: exactly one bubble per hazard. The dependent instruction re-evaluates in ID next cycle, when the load has moved to MEM and the hazard clears.
- A branch taken in the same cycle as a load-use condition gets redirect behaviour only; StallCount does not increment.

## Test plan
- Reset mid-run with Reset_n=0 between edges:
  - Outputs go to reset values without waiting for a clock.
  - Counters read 0.
  - After release, idle RUN outputs.
- BranchTaken_M=1, Target_M=0x00400040 at cycle t:
  - Cycle t: three flushes=1, PCWrite=0.
  - Cycle t+1: PCSrc=1, PCWrite=1, IFID_Flush=1, RedirectPC=0x00400040.
  - Cycle t+2: idle.
  - FlushCount=2.
- MemRead_E=1, Rt_E=8, Rs_D=8:
  - One cycle of PCWrite=0, IFID_Write=0, IDEX_Flush=1; StallCount=1.
  - Repeat with Rt_E=0: no stall.
  - Repeat with Rt_E=8, Rt_D=8, UsesRt_D=0: no stall.
- BranchTaken_M=1 together with a load-use match:
  - Redirect sequence only; StallCount unchanged.
  - BranchTaken_M=1 held through t+1 is ignored in REDIRECT; FlushCount=2.
- Preload FlushCount to 0xFFFFFFFE via a forced redirect stream, then issue 2 more redirects:
  - Counter stops at 0xFFFFFFFF and holds.
- Reset asserted in REDIRECT cycle t+1:
  - PCSrc=0 immediately; RedirectPC=0; no target load observed on PC.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// PC redirect and hazard control for a 5-stage pipeline with branch resolution in MEM.
// Branch or jump taken in MEM: capture the target, squash the wrong path, then load the PC
// from the captured target one cycle later. Load-use hazard: insert a single bubble.
// Two saturating counters track cycles lost to redirects and to stalls.
module pc_redirect_ctrl (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        BranchTaken_M,
  input  logic [31:0] Target_M,
  input  logic        MemRead_E,
  input  logic [4:0]  Rt_E,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic        UsesRt_D,
  output logic        PCSrc,
  output logic [31:0] RedirectPC,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic [31:0] FlushCount,
  output logic [31:0] StallCount
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic        load_use;
  logic        capture;
  logic        flush_inc;
  logic        stall_inc;
  logic [31:0] redirect_pc;
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;

  assign load_use = MemRead_E && (Rt_E != 5'd0) &&
                    ((Rt_E == Rs_D) || (UsesRt_D && (Rt_E == Rt_D)));

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Next state and control outputs; the branch takes priority over the load-use bubble
  always_comb begin
    state_nxt   = state;
    PCSrc       = 1'b0;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    capture     = 1'b0;
    flush_inc   = 1'b0;
    stall_inc   = 1'b0;
    case (state)
      RUN: begin
        if (BranchTaken_M) begin
          capture     = 1'b1;
          flush_inc   = 1'b1;
          PCWrite     = 1'b0;
          IFID_Flush  = 1'b1;
          IDEX_Flush  = 1'b1;
          EXMEM_Flush = 1'b1;
          state_nxt   = REDIRECT;
        end else if (load_use) begin
          stall_inc   = 1'b1;
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Flush  = 1'b1;
        end
      end
      REDIRECT: begin
        // EX/MEM already holds a bubble from the capture cycle, so only IF/ID is squashed here
        flush_inc  = 1'b1;
        PCSrc      = 1'b1;
        IFID_Flush = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Redirect target capture, held outside the capture cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     redirect_pc <= '0;
    else if (capture) redirect_pc <= Target_M;
  end

  // Saturating lost-cycle counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign RedirectPC = redirect_pc;
  assign FlushCount = flush_cnt;
  assign StallCount = stall_cnt;

endmodule
